// File: rtl/fetch_queue.sv
// fetch_queue: MIPS fetch stage with req/ack imem port and in-order prefetch queue.
// Define FETCH_QUEUE_BYPASS_EN to forward a returning word straight to the output when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     hold,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx, req_pc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic live, empty, issue, push, pop, byp, byp_take;
  assign empty = count == '0;
  // live holds off the first request until the first edge after reset release
  assign issue = live && state == IDLE && count != FULL && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = state == WAIT && imem_ack && empty;
`else
  assign byp = 1'b0;
`endif
  assign byp_take = byp && !hold && !redirect;
  assign push = state == WAIT && imem_ack && !redirect && !byp_take;
  assign pop = !empty && !hold && !redirect;
  assign imem_req = state != IDLE || issue;
  assign imem_addr = state == IDLE ? fetch_pc : req_pc;
  assign inst_valid = byp || !empty;
  assign inst_out = byp ? imem_rdata : empty ? 32'h0 : inst_q[rd_ptr];
  assign pc_out = byp ? req_pc : empty ? 32'h0 : pc_q[rd_ptr];
  always_comb begin
    state_nx = state;
    fetch_pc_nx = fetch_pc;
    case (state)
      IDLE: state_nx = issue ? WAIT : IDLE;
      WAIT: begin
        state_nx = imem_ack ? IDLE : redirect ? DISCARD : WAIT;
        fetch_pc_nx = imem_ack ? fetch_pc + 32'd4 : fetch_pc;
      end
      DISCARD: state_nx = imem_ack ? IDLE : DISCARD;
      default: state_nx = IDLE;
    endcase
    if (redirect) fetch_pc_nx = redirect_pc;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      live <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      fetch_pc <= fetch_pc_nx;
      if (issue) req_pc <= fetch_pc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr] <= req_pc;
    end
  end
endmodule
